pipeline_core: RTL and testbench
================================

# pipeline_core

Parametrised successor of the two-stage decode/execute debug core. It accepts instructions over a valid/ready handshake, reads a 16-entry register file, executes in an ALU with EX→ID forwarding, and writes back. An iterative multiplier stalls the front end during its multi-cycle execution. The block sits between the debug instruction source and the writeback observation port, and is the core datapath of the CPU.

## Interface
- XLEN, 32, datapath and register width; power of two, ≥8
- RESET_PC_TAG, 0, initial value of the retired-instruction counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_valid  in  1  instruction on inst is valid
- inst_ready  out  1  core accepts inst this cycle
- inst  in  32  op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0]
- wb_valid  out  1  one-cycle pulse per retired writing instruction
- wb_rd  out  4  destination register of retired instruction
- wb_data  out  XLEN  result of retired instruction
- retired  out  32  count of retired instructions, NOPs included

## Operation
- Reset value of every output is 0, except retired = RESET_PC_TAG and inst_ready = 1 once reset is released. All registers r1..r15 reset to 0. r0 reads 0, and writes to it are dropped.
- Acceptance: an instruction is accepted on a rising edge where inst_valid && inst_ready. During the accept cycle, ID reads rs1/rs2 combinationally and sign-extends imm to XLEN. It then captures op, rd and operands into the ID/EX register.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SLL and 7 SRL, with shift amount rs2[log2(XLEN)-1:0]
  - 8 SLT, signed, result 0/1
  - 9 ADDI (rs1 + sext(imm))
  - 10 LUI (sext(imm) << 16, truncated to XLEN)
  - 11 MUL (low XLEN bits of rs1*rs2, unsigned shift-add)
  - 12–15 behave as NOP
- All arithmetic is modulo 2^XLEN.
- Forwarding: if the instruction in EX completes in the same cycle that ID reads a register, and its rd ≠ 0 matches rs1 or rs2, ID takes the EX result instead of the register file. No other hazard exists.
- Writeback: on the EX completion edge, wb_valid/wb_rd/wb_data are registered and the register file is written in the same edge. NOP and ops 12–15 retire with wb_valid = 0, but still increment retired. rd = 0 gives wb_valid = 1 with wb_rd = 0 and no register file write.
- EX state machine:
  - IDLE: ALU ops complete in one cycle.
  - On a MUL entering ID/EX, the state goes to MUL with cnt = 0. In MUL, the state machine shifts the multiplier right and adds the multiplicand when the low bit is set, for XLEN cycles. It completes when cnt = XLEN-1 and returns to IDLE.
  - inst_ready = 0 whenever EX holds an incomplete MUL.
- retired increments by 1 on every EX completion and wraps at 2^32.
- Asynchronous reset asserted mid-MUL aborts the MUL with no retirement and returns every register to its reset value.

## Timing
- ALU op accepted at edge N: wb_valid is high in the cycle after edge N+1, for exactly one cycle unless it is followed back-to-back.
- Back-to-back ALU ops sustain one retirement per cycle, with inst_ready constantly 1.
- MUL accepted at edge N: inst_ready is low from after edge N until the completion edge N+XLEN. wb_valid is high after edge N+XLEN. The next instruction can be accepted at edge N+XLEN, and its ID read forwards the MUL result.
- inst_ready is combinational from state only, never from inst_valid.
- inst_valid low: bubbles propagate, with no retirement and no wb_valid.

## Test plan
- Reset release, then ADDI r1,r0,5 → wb_valid after 2 edges, wb_rd=1, wb_data=5, retired=1.
- Dependent back-to-back: ADDI r1,r0,7; ADD r2,r1,r1; SUB r3,r2,r1 on consecutive cycles → wb_data 7, 14, 7 on consecutive cycles (forwarding).
- ADDI r4,r0,-1 (imm 0xFFFF); SRL r5,r4,r(=31); SLT r6,r4,r0 → 0xFFFFFFFF, 1, 1.
- MUL r7,r1,r2 with r1=7, r2=14 (XLEN=32) → inst_ready low for 31 cycles, wb_data=98 after edge N+32; the following ADD r8,r7,r0 yields 98.
- Write to r0 and NOP/op 13 → r0 still reads 0; retired increments, wb_valid low for NOP/op 13.
- rst low asserted mid-MUL → outputs 0 immediately, inst_ready=1 after release, r1..r15 read 0, and the aborted MUL never retires.

Source files
------------

// File: rtl/pipeline_core.sv
// pipeline_core: two-stage decode/execute core with 16-entry register file, EX->ID forwarding, iterative multiplier.
// Latency: ALU op accepted at edge N retires (wb_*_o registered) at edge N+1; MUL retires at edge N+XLEN.
// Backpressure: inst_ready_o depends only on EX state; it drops while an incomplete MUL occupies EX.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   inst_valid_i/_ready_o  instruction handshake; inst_i = op[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm[15:0]
//   wb_valid_o/_rd_o/_data_o  one-cycle writeback pulse per retired writing instruction
//   retired_o              retired-instruction counter (NOPs included), resets to RESET_PC_TAG
module pipeline_core #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'd0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [31:0]     inst_i,
    output logic            wb_valid_o,
    output logic [3:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [31:0]     retired_o
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    // ---------------- state ----------------
    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             ex_vld_q;
    logic [3:0]       ex_op_q;
    logic [3:0]       ex_rd_q;
    logic [XLEN-1:0]  ex_a_q;       // operand A; multiplicand (shifted left) during MUL
    logic [XLEN-1:0]  ex_b_q;       // operand B; multiplier (shifted right) during MUL
    logic [XLEN-1:0]  acc_q;        // MUL partial product
    logic [XLEN-1:0]  rf_q [16];
    logic             wb_valid_q;
    logic [3:0]       wb_rd_q;
    logic [XLEN-1:0]  wb_data_q;
    logic [31:0]      retired_q;

    // ---------------- control ----------------
    logic cnt_last;
    logic ex_done;
    logic accept;
    logic ex_writes;
    logic ex_fwd;

    // ---------------- decode ----------------
    logic [3:0]       id_op, id_rs1, id_rs2;
    logic [XLEN+15:0] imm_ext;
    logic [XLEN-1:0]  id_imm, rs1_val, rs2_val, id_a, id_b;
    logic [XLEN-1:0]  alu_res, mul_sum, ex_result;

    assign id_op   = inst_i[31:28];
    assign id_rs1  = inst_i[23:20];
    assign id_rs2  = inst_i[19:16];
    assign imm_ext = {{XLEN{inst_i[15]}}, inst_i[15:0]};
    assign id_imm  = imm_ext[XLEN-1:0];

    assign cnt_last  = (cnt_q == SHW'(XLEN - 1));
    assign accept    = inst_valid_i && inst_ready_o;
    // Ops 1..11 produce a result; 0 and 12..15 retire silently.
    assign ex_writes = (ex_op_q != OP_NOP) && (ex_op_q <= OP_MUL);
    assign ex_fwd    = ex_done && ex_writes && (ex_rd_q != 4'd0);

    // Register read with bypass of the result completing in EX this cycle.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (id_rs1 != 4'd0) begin
            rs1_val = (ex_fwd && ex_rd_q == id_rs1) ? ex_result : rf_q[id_rs1];
        end
        if (id_rs2 != 4'd0) begin
            rs2_val = (ex_fwd && ex_rd_q == id_rs2) ? ex_result : rf_q[id_rs2];
        end
    end

    assign id_a = rs1_val;
    assign id_b = (id_op == OP_ADDI || id_op == OP_LUI) ? id_imm : rs2_val;

    // ---------------- execute ----------------
    always_comb begin
        alu_res = '0;
        case (ex_op_q)
            OP_ADD:  alu_res = ex_a_q + ex_b_q;
            OP_SUB:  alu_res = ex_a_q - ex_b_q;
            OP_AND:  alu_res = ex_a_q & ex_b_q;
            OP_OR:   alu_res = ex_a_q | ex_b_q;
            OP_XOR:  alu_res = ex_a_q ^ ex_b_q;
            OP_SLL:  alu_res = ex_a_q << ex_b_q[SHW-1:0];
            OP_SRL:  alu_res = ex_a_q >> ex_b_q[SHW-1:0];
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
            OP_ADDI: alu_res = ex_a_q + ex_b_q;
            OP_LUI:  alu_res = ex_b_q << 16;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step; on the last step this is already the final product.
    assign mul_sum   = acc_q + (ex_b_q[0] ? ex_a_q : '0);
    assign ex_result = (state_q == S_MUL) ? mul_sum : alu_res;

    // ---------------- EX FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_MUL) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_last) begin
                state_d = S_IDLE;
            end
        end
        // A MUL may be accepted on the completion edge of the previous one.
        if (accept && id_op == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
        end
    end

    always_comb begin
        inst_ready_o = !((state_q == S_MUL) && !cnt_last);
        // In IDLE a valid EX slot always holds a single-cycle op.
        ex_done      = ex_vld_q && ((state_q == S_IDLE) || cnt_last);
    end

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_vld_q <= 1'b0;
            ex_op_q  <= '0;
            ex_rd_q  <= '0;
            ex_a_q   <= '0;
            ex_b_q   <= '0;
            acc_q    <= '0;
        end else if (accept) begin
            ex_vld_q <= 1'b1;
            ex_op_q  <= id_op;
            ex_rd_q  <= inst_i[27:24];
            ex_a_q   <= id_a;
            ex_b_q   <= id_b;
            acc_q    <= '0;
        end else if (ex_done) begin
            ex_vld_q <= 1'b0;
        end else if (state_q == S_MUL) begin
            acc_q  <= mul_sum;
            ex_a_q <= ex_a_q << 1;
            ex_b_q <= ex_b_q >> 1;
        end
    end

    // ---------------- writeback ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            retired_q  <= RESET_PC_TAG;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= ex_done && ex_writes;
            if (ex_done && ex_writes) begin
                wb_rd_q   <= ex_rd_q;
                wb_data_q <= ex_result;
                if (ex_rd_q != 4'd0) begin
                    rf_q[ex_rd_q] <= ex_result;
                end
            end
            if (ex_done) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_pipeline_core.sv
module tb_pipeline_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_ready;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retired;

    pipeline_core #(.XLEN(32), .RESET_PC_TAG(32'd0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .inst_valid_i (inst_valid),
        .inst_ready_o (inst_ready),
        .inst_i       (inst),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .retired_o    (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expectation, including its edge.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h at edge %0d, required no writeback",
                         wb_rd, wb_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (wb_rd !== mon_e.rd || wb_data !== mon_e.data || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL wb_match: got rd=%0d data=%h edge=%0d, required rd=%0d data=%h edge=%0d",
                             wb_rd, wb_data, cyc, mon_e.rd, mon_e.data, mon_e.at);
                end
            end
        end
    end

    // Call just after a falling edge. Holds the instruction until accepted.
    task automatic send(input logic [31:0] ins, input bit wb, input logic [3:0] rd,
                        input logic [31:0] data, input int lat, output int waits);
        waits = 0;
        inst = ins;
        inst_valid = 1'b1;
        while (!inst_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got inst_ready=0 after %0d cycles, required 1", waits);
        end
        @(posedge clk);
        #1;
        if (wb) sb.push_back('{rd, data, cyc + lat});
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    task automatic go(input logic [31:0] ins, input logic [3:0] rd, input logic [31:0] data);
        int w;
        send(ins, 1'b1, rd, data, 1, w);
    endtask

    task automatic nowb(input logic [31:0] ins);
        int w;
        send(ins, 1'b0, 4'd0, 32'd0, 1, w);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d writebacks outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", {31'd0, inst_ready}, 32'd1);

        // First ADDI: writeback two edges after issue
        go(mk(4'd9, 4'd1, 4'd0, 4'd0, 16'd5), 4'd1, 32'd5);
        drain();
        chk("retired_first", retired, 32'd1);

        // Back-to-back dependent chain through forwarding
        go(mk(4'd9, 4'd1, 4'd0, 4'd0, 16'd7), 4'd1, 32'd7);
        go(mk(4'd1, 4'd2, 4'd1, 4'd1, 16'd0), 4'd2, 32'd14);
        go(mk(4'd2, 4'd3, 4'd2, 4'd1, 16'd0), 4'd3, 32'd7);

        // Sign extension, shifts, signed compare
        go(mk(4'd9, 4'd4, 4'd0, 4'd0, 16'hFFFF), 4'd4, 32'hFFFF_FFFF);
        go(mk(4'd9, 4'd9, 4'd0, 4'd0, 16'd31), 4'd9, 32'd31);
        go(mk(4'd7, 4'd5, 4'd4, 4'd9, 16'd0), 4'd5, 32'd1);
        go(mk(4'd8, 4'd6, 4'd4, 4'd0, 16'd0), 4'd6, 32'd1);

        // Remaining ALU ops
        go(mk(4'd10, 4'd11, 4'd0, 4'd0, 16'h8001), 4'd11, 32'h8001_0000);
        go(mk(4'd3, 4'd12, 4'd4, 4'd9, 16'd0), 4'd12, 32'h0000_001F);
        go(mk(4'd4, 4'd13, 4'd1, 4'd2, 16'd0), 4'd13, 32'h0000_000F);
        go(mk(4'd5, 4'd14, 4'd1, 4'd2, 16'd0), 4'd14, 32'h0000_0009);
        go(mk(4'd6, 4'd15, 4'd1, 4'd9, 16'd0), 4'd15, 32'h8000_0000);

        // MUL 7*14: 31 stalled cycles, result at +32, forwarded into the next ADD
        send(mk(4'd11, 4'd7, 4'd1, 4'd2, 16'd0), 1'b1, 4'd7, 32'd98, 32, w);
        send(mk(4'd1, 4'd8, 4'd7, 4'd0, 16'd0), 1'b1, 4'd8, 32'd98, 1, w);
        chk("mul_stall_cycles", w, 32'd31);

        // r0 write dropped, no forwarding from rd=0, silent retirements
        go(mk(4'd9, 4'd0, 4'd0, 4'd0, 16'd9), 4'd0, 32'd9);
        go(mk(4'd1, 4'd10, 4'd0, 4'd0, 16'd0), 4'd10, 32'd0);
        nowb(mk(4'd0, 4'd3, 4'd1, 4'd2, 16'd1));
        nowb(mk(4'd13, 4'd3, 4'd1, 4'd2, 16'd1));
        go(mk(4'd1, 4'd12, 4'd3, 4'd0, 16'd0), 4'd12, 32'd7);
        drain();
        chk("retired_total", retired, 32'd20);

        // Reset in the middle of a MUL
        inst = mk(4'd11, 4'd7, 4'd1, 4'd2, 16'd0);
        inst_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmul_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midmul_wb_rd", {28'd0, wb_rd}, 32'd0);
        chk("midmul_wb_data", wb_data, 32'd0);
        chk("midmul_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midmul_rdy", {31'd0, inst_ready}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            go(mk(4'd1, 4'd0, 4'(i), 4'd0, 16'd0), 4'd0, 32'd0);
        end
        drain();
        repeat (40) @(negedge clk);
        chk("post_rst_retired", retired, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required completion");
        $fatal(1);
    end

endmodule
